// File: rtl/if_prefetch_if.sv
// Bundle between the fetch front end, the instruction memory and the IF_ID stage.
// master = prefetcher view, slave = memory/IF_ID view.
interface if_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_next_out;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_next_out,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_next_out,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetcher: one-outstanding imem fetch, DEPTH-entry FIFO toward IF_ID, redirect flush.
// Define IF_PREFETCH_PERF_EN to add the bubble_cnt / flush_cnt performance counters.
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
`ifdef IF_PREFETCH_PERF_EN
  output logic [31:0] bubble_cnt,
  output logic [15:0] flush_cnt,
`endif
  if_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic          r_req, w_req_nxt;
  logic [31:0]   r_inst_out, w_inst_out_nxt;
  logic [31:0]   r_pc_out, w_pc_out_nxt;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic          w_gnt, w_push, w_pop;
  logic          w_unused;

  // r_req already encodes IDLE with a free slot, so a grant is only honoured while it is up
  assign w_gnt    = r_req & bus.imem_gnt;
  assign w_pop    = (r_count != {CW{1'b0}}) & bus.inst_ready & ~bus.redirect;
  assign w_push   = (r_state == ST_WAIT) & bus.imem_rvalid & ~bus.redirect;
  assign w_unused = ^bus.redirect_pc[1:0];

  // Next-state logic for the request FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = bus.redirect ? ST_DROP : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.redirect) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fetch address, FIFO bookkeeping and next head contents
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_count_nxt    = r_count;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_inst_out_nxt = r_inst_out;
    w_pc_out_nxt   = r_pc_out;
    if (bus.redirect) begin
      w_fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
      w_count_nxt    = {CW{1'b0}};
      w_wr_ptr_nxt   = {AW{1'b0}};
      w_rd_ptr_nxt   = {AW{1'b0}};
    end else begin
      if (w_gnt) begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end
      w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
      w_wr_ptr_nxt = r_wr_ptr + AW'(w_push);
      w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
      // In WAIT the fetch PC is already requested_addr + 4
      if (w_count_nxt == {CW{1'b0}}) begin
        w_inst_out_nxt = r_inst_out;
        w_pc_out_nxt   = r_pc_out;
      end else if ((r_count - CW'(w_pop)) == {CW{1'b0}}) begin
        w_inst_out_nxt = bus.imem_rdata;
        w_pc_out_nxt   = r_fetch_pc;
      end else begin
        w_inst_out_nxt = r_mem_inst[w_rd_ptr_nxt];
        w_pc_out_nxt   = r_mem_pc[w_rd_ptr_nxt];
      end
    end
    w_req_nxt = (w_state_nxt == ST_IDLE) && (w_count_nxt < DEPTH_C);
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= {CW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_req      <= 1'b0;
      r_inst_out <= 32'd0;
      r_pc_out   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_req      <= w_req_nxt;
      r_inst_out <= w_inst_out_nxt;
      r_pc_out   <= w_pc_out_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.inst_valid  = (r_count != {CW{1'b0}});
  assign bus.inst_out    = r_inst_out;
  assign bus.pc_next_out = r_pc_out;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating bubble and flush counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= 32'd0;
      r_flush_cnt  <= 16'd0;
    end else begin
      if (bus.inst_ready && (r_count == {CW{1'b0}}) && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (bus.redirect && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: behavioural stream model (queue of fetched PCs) plus directed literal checks.
module tb_if_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock;
  logic reset;
  if_prefetch_if bus();
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [15:0] flush_cnt;
`endif

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef IF_PREFETCH_PERF_EN
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: PCs whose words must appear at the FIFO head, in order
  logic [31:0] q[$];
  logic        pend_valid, pend_stale;
  logic [31:0] pend_addr;
  int          pend_due;
  logic [31:0] exp_fetch;
  int          exp_bubble, exp_flush;

  // Stimulus knobs
  int          gnt_pct, rdy_pct, rdr_permille, lat_lo, lat_hi;
  logic        force_rdr, spur_rv;
  logic [31:0] force_pc;

  // Observations for directed checks
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];
  int          n_grants, first_gnt_cyc, first_valid_cyc;
  logic        smp_req, smp_valid;
  logic [31:0] smp_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    pop_log.delete();
    n_grants        = 0;
    first_gnt_cyc   = -1;
    first_valid_cyc = -1;
  endtask

  task automatic do_reset(input bit spur);
    reset              = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.inst_ready     = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'd0;
    q.delete();
    pend_valid = 1'b0;
    pend_stale = 1'b0;
    exp_fetch  = RESET_PC;
    exp_bubble = 0;
    exp_flush  = 0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_pc_next_out", bus.pc_next_out, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    if (spur) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom();
    end
  endtask

  // One cycle: compare DUT outputs with the model, drive inputs, advance the model
  task automatic step();
    logic g, rv, rd, rr, ok, mvalid;
    logic [31:0] rpc;
    @(negedge clock);
    cyc++;
    smp_req   = bus.imem_req;
    smp_valid = bus.inst_valid;
    smp_addr  = bus.imem_addr;
    mvalid    = (q.size() != 0);
    chk("inst_valid", 32'(bus.inst_valid), 32'(mvalid));
    if (mvalid) begin
      chk("inst_out", bus.inst_out, memf(q[0]));
      chk("pc_next_out", bus.pc_next_out, q[0] + 32'd4);
    end
    if (pend_valid || q.size() >= DEPTH) chk("imem_req_off", 32'(bus.imem_req), 32'd0);
    else chk("imem_req_on", 32'(bus.imem_req), 32'd1);
    if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_fetch);
`ifdef IF_PREFETCH_PERF_EN
    chk("bubble_cnt", bubble_cnt, 32'(exp_bubble));
    chk("flush_cnt", 32'(flush_cnt), 32'(exp_flush & 32'h0000_FFFF));
`endif
    if (bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    g   = bus.imem_req && ($urandom_range(99) < 32'(gnt_pct));
    rv  = (pend_valid && cyc >= pend_due) || (spur_rv && !pend_valid);
    rd  = ($urandom_range(99) < 32'(rdy_pct));
    rr  = force_rdr || ($urandom_range(999) < 32'(rdr_permille));
    rpc = force_rdr ? force_pc : $urandom();
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = (pend_valid && rv) ? memf(pend_addr) : $urandom();
    bus.inst_ready  = rd;
    bus.redirect    = rr;
    bus.redirect_pc = rpc;

    if (rd && !mvalid) exp_bubble++;
    if (rr) exp_flush++;
    ok = pend_valid && rv && !pend_stale && !rr;
    if (pend_valid && rv) pend_valid = 1'b0;
    if (rr) begin
      q.delete();
    end else begin
      if (mvalid && rd) begin
        pop_log.push_back(bus.pc_next_out);
        void'(q.pop_front());
      end
      if (ok) q.push_back(pend_addr);
    end
    if (g) begin
      n_grants++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      grant_log.push_back(exp_fetch);
      pend_valid = 1'b1;
      pend_stale = rr;
      pend_addr  = exp_fetch;
      pend_due   = cyc + $urandom_range(lat_hi, lat_lo);
      exp_fetch  = exp_fetch + 32'd4;
    end
    if (rr) begin
      exp_fetch = {rpc[31:2], 2'b00};
      if (pend_valid) pend_stale = 1'b1;
    end
  endtask

  task automatic knobs(input int g, input int r, input int rdr, input int lo, input int hi);
    gnt_pct = g; rdy_pct = r; rdr_permille = rdr; lat_lo = lo; lat_hi = hi;
    force_rdr = 1'b0; spur_rv = 1'b0;
  endtask

  initial begin
    int budget;
    knobs(100, 100, 0, 1, 1);
    force_pc = 32'd0;
    clear_logs();

    // Reset release, single-cycle memory, IF_ID always ready
    do_reset(1'b0);
    clear_logs();
    repeat (12) step();
    chk("seq_addr0", grant_log[0], 32'h0);
    chk("seq_addr1", grant_log[1], 32'h4);
    chk("seq_addr2", grant_log[2], 32'h8);
    chk("first_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
    chk("seq_pcn0", pop_log[0], 32'h4);
    chk("seq_pcn1", pop_log[1], 32'h8);
    chk("seq_pcn2", pop_log[2], 32'hC);

    // Stall until the FIFO fills, then drain
    do_reset(1'b0);
    knobs(100, 0, 0, 1, 1);
    clear_logs();
    repeat (20) step();
    chk("full_grants", 32'(n_grants), 32'd4);
    chk("full_req_low", 32'(smp_req), 32'd0);
    spur_rv = 1'b1;
    repeat (3) step();
    knobs(100, 100, 0, 1, 1);
    clear_logs();
    repeat (12) step();
    chk("drain0", pop_log[0], 32'h4);
    chk("drain1", pop_log[1], 32'h8);
    chk("drain2", pop_log[2], 32'hC);
    chk("drain3", pop_log[3], 32'h10);
    chk("resume_addr", grant_log[0], 32'h10);

    // Redirect while WAIT, latency 3
    do_reset(1'b0);
    knobs(100, 100, 0, 3, 3);
    budget = 0;
    while (!pend_valid && budget < 20) begin step(); budget++; end
    if (!pend_valid) expire("wait_grant");
    force_rdr = 1'b1; force_pc = 32'h40;
    step();
    force_rdr = 1'b0;
    clear_logs();
    repeat (15) step();
    chk("rdr_wait_addr", grant_log[0], 32'h40);
    chk("rdr_wait_pcn", pop_log[0], 32'h44);

    // Redirect in the same cycle as gnt
    do_reset(1'b0);
    knobs(100, 0, 0, 1, 1);
    force_rdr = 1'b1; force_pc = 32'h43;
    step();
    force_rdr = 1'b0;
    clear_logs();
    step();
    chk("gnt_rdr_req_low", 32'(smp_req), 32'd0);
    chk("gnt_rdr_empty", 32'(smp_valid), 32'd0);
    repeat (4) step();
    chk("gnt_rdr_addr", grant_log[0], 32'h40);

    // Redirect in the same cycle as rvalid, FIFO non-empty
    knobs(100, 0, 0, 2, 2);
    budget = 0;
    while (!(pend_valid && pend_due == cyc + 1 && q.size() > 0) && budget < 40) begin
      step(); budget++;
    end
    if (!(pend_valid && pend_due == cyc + 1)) expire("rvalid_align");
    force_rdr = 1'b1; force_pc = 32'h80;
    step();
    force_rdr = 1'b0;
    clear_logs();
    step();
    chk("rv_rdr_req_high", 32'(smp_req), 32'd1);
    chk("rv_rdr_empty", 32'(smp_valid), 32'd0);
    repeat (4) step();
    chk("rv_rdr_addr", grant_log[0], 32'h80);

    // Randomized traffic
    do_reset(1'b0);
    knobs(60, 70, 30, 1, 4);
    repeat (3000) step();
    knobs(80, 20, 15, 1, 3);
    repeat (3000) step();

    // Async reset mid-WAIT with two queued entries
    knobs(100, 0, 0, 3, 3);
    do_reset(1'b0);
    budget = 0;
    while (!(q.size() == 2 && pend_valid) && budget < 50) begin step(); budget++; end
    if (!(q.size() == 2 && pend_valid)) expire("mid_wait_setup");
    step();
    @(posedge clock);
    #2;
    do_reset(1'b1);
    knobs(100, 100, 0, 1, 1);
    clear_logs();
    step();
    chk("post_rst_addr", smp_addr, RESET_PC);
    repeat (10) step();
    chk("post_rst_pcn", pop_log[0], 32'h4);

`ifdef IF_PREFETCH_PERF_EN
    do_reset(1'b0);
    knobs(0, 100, 0, 1, 1);
    repeat (5) step();
    rdy_pct = 0;
    force_rdr = 1'b1; force_pc = 32'h100;
    repeat (2) step();
    force_rdr = 1'b0;
    step();
    chk("perf_bubble", bubble_cnt, 32'd5);
    chk("perf_flush", 32'(flush_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction-fetch front end that sits directly upstream of the IF_ID pipeline register.
- Generates the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers returned words with their PC+4 in a small FIFO and presents them to IF_ID through a valid/ready handshake.
- Handles branch redirects by flushing queued and in-flight fetches.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  request byte address, word aligned
imem_gnt  input  1  memory accepts request this cycle; meaningful only when imem_req=1
imem_rvalid  input  1  read data valid; at most one per granted request, earliest one cycle after gnt
imem_rdata  input  32  instruction word
inst_valid  output  1  FIFO head valid toward IF_ID
inst_out  output  32  head instruction
pc_next_out  output  32  head fetch address + 4
inst_ready  input  1  IF_ID consumes head this cycle (0 = stall)
redirect  input  1  single-cycle taken-branch pulse (PCSrc)
redirect_pc  input  32  branch target

Behaviour:
- Reset is asynchronous and active-high. Clock port is clock, reset port is reset. This is fixed.
- Reset, asserted at any time including mid-request, forces the following values:
  - fetch_pc = RESET_PC
  - FIFO count = 0, read and write pointers = 0
  - state = IDLE
  - imem_req = 0, inst_valid = 0, inst_out = 0, pc_next_out = 0
- The FSM has three states: IDLE, WAIT, DROP.
- IDLE:
  - imem_req=1 when (count + 0) < DEPTH, i.e. a slot is free. imem_addr = fetch_pc.
  - The request is held stable until gnt.
  - On gnt: state -> WAIT, fetch_pc += 4 (wraps modulo 2^32), and a FIFO slot is reserved.
- WAIT:
  - imem_req=0.
  - On rvalid: push {imem_rdata, requested_addr+4}, release the reservation, state -> IDLE. The next request may issue the following cycle.
- DROP:
  - imem_req=0.
  - On rvalid: discard the data, state -> IDLE.
- Issue condition: a request issues only if count + reserved < DEPTH. An arriving response therefore always has a slot, and the FIFO never overflows.
- Output path:
  - inst_valid = (count != 0). inst_out and pc_next_out are registered FIFO-head contents.
  - Pop occurs when inst_valid & inst_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When empty, the FIFO holds inst_out/pc_next_out at their last values with inst_valid=0. IF_ID must insert a bubble (nop, 32'b0).
- Redirect has priority over every other event in its cycle:
  - FIFO is flushed (count=0) and any pop that cycle is ignored.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low address bits are ignored.
  - IDLE with gnt in the same cycle: the granted request is stale, state -> DROP.
  - IDLE without gnt: the pending request is withdrawn; the next cycle requests the new target.
  - WAIT without rvalid: state -> DROP.
  - WAIT or DROP with rvalid in the same cycle: the response is discarded, state -> IDLE.
  - DROP: state stays DROP until rvalid arrives.
  - inst_valid = 0 in the cycle after redirect.
- Back-to-back redirects: the last one wins. At most one stale response is ever outstanding.
- Minimum latency, with a single-cycle memory and an empty FIFO: gnt at cycle N, rvalid at N+1, inst_valid at N+2.

Optional Feature:
- Macro IF_PREFETCH_PERF_EN.
- When defined, two extra output ports are added:
  - bubble_cnt (32): increments each cycle inst_ready=1 & inst_valid=0.
  - flush_cnt (16): increments on each redirect.
  - Both counters saturate at all-ones and reset to 0.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - inst_out follows memory contents with pc_next_out 0x4, 0x8, 0xC.
  - First inst_valid arrives 2 cycles after the first gnt.
- inst_ready held 0 with DEPTH=4:
  - Exactly 4 grants occur, then imem_req stays 0.
  - Releasing inst_ready drains 4 in-order entries; requests resume at 0x10.
- Redirect to 0x40 while in WAIT, with memory latency 3:
  - The stale rvalid is discarded.
  - The next imem_addr is 0x40 and the next inst_valid entry has pc_next_out=0x44.
  - No entry from the old stream appears.
- Redirect in the same cycle as gnt, and separately in the same cycle as rvalid:
  - The FSM goes to DROP and IDLE respectively.
  - FIFO is empty the next cycle.
  - redirect_pc=0x43 fetches 0x40.
- Async reset asserted mid-WAIT with 2 FIFO entries:
  - Outputs are zero immediately, without waiting for a clock edge.
  - After release, imem_addr=RESET_PC.
  - A late rvalid while in IDLE with imem_req low is ignored.
- With IF_PREFETCH_PERF_EN defined:
  - 5 empty cycles with inst_ready=1 plus 2 redirects give bubble_cnt=5 and flush_cnt=2.
